// File: rtl/inv_key_schedule_pkg.sv
// rtl/inv_key_schedule_pkg.sv - shared constants, FSM state type and rcon table for the inverse key schedule
package inv_key_schedule_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index is the destination round (r-1); out-of-range indices return zero.
  function automatic logic [31:0] rcon(input logic [3:0] idx);
    logic [31:0] r;
    case (idx)
      4'd0:    r = 32'h0100_0000;
      4'd1:    r = 32'h0200_0000;
      4'd2:    r = 32'h0400_0000;
      4'd3:    r = 32'h0800_0000;
      4'd4:    r = 32'h1000_0000;
      4'd5:    r = 32'h2000_0000;
      4'd6:    r = 32'h4000_0000;
      4'd7:    r = 32'h8000_0000;
      4'd8:    r = 32'h1b00_0000;
      4'd9:    r = 32'h3600_0000;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// rtl/inv_key_schedule_if.sv - request/round-key stream bundle between a key consumer and the inverse key schedule
interface inv_key_schedule_if;
  import inv_key_schedule_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_out;
  logic [3:0]       key_round;
  logic             key_valid;
  logic             key_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, key_in, key_ready,
    input  key_out, key_round, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_out, key_round, key_valid, busy, done
  );

endinterface

// File: rtl/forward_substitution_box.sv
// rtl/forward_substitution_box.sv - AES forward S-box, one byte, purely combinational lookup
module forward_substitution_box (
  input  logic [7:0] value,
  output logic [7:0] result
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign result = SBOX[value];

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - walks an AES-128 round-10 key back to round 0, one round key per accepted beat
module inv_key_schedule
  import inv_key_schedule_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  inv_key_schedule_if.slave  kif
);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, key_step;
  logic [3:0]       round_q, round_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             fire;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1_n, w2_n, w3_n, w0_n;
  logic [31:0] rot, sub;

  // The step is computed straight off key_q so a round retires every accepted cycle.
  assign {w0, w1, w2, w3} = key_q;
  assign w3_n = w3 ^ w2;
  assign w2_n = w2 ^ w1;
  assign w1_n = w1 ^ w0;
  assign rot  = rot_word(w3_n);

  for (genvar i = 0; i < 4; i++) begin : g_sub
    forward_substitution_box u_sbox (
      .value  (rot[8*i +: 8]),
      .result (sub[8*i +: 8])
    );
  end

  assign w0_n     = w0 ^ sub ^ rcon(round_q - 4'd1);
  assign key_step = {w0_n, w1_n, w2_n, w3_n};

  assign fire = valid_q & kif.key_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          key_d   = kif.key_in;
          round_d = 4'(NUM_ROUNDS);
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (fire) begin
          if (round_q != 4'd0) begin
            key_d   = key_step;
            round_d = round_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign kif.key_out   = key_q;
  assign kif.key_round = round_q;
  assign kif.key_valid = valid_q;
  assign kif.busy      = (state_q == RUN);
  assign kif.done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - randomized self-checking bench against a forward-expansion AES key model
module tb_inv_key_schedule;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_key_schedule_if kif ();

  inv_key_schedule u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]   msbox [256];
  logic [127:0] exp_keys [0:10];

  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // GF(2^8) arithmetic, used to derive the S-box from its algebraic definition.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      logic [7:0] r;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl8(r);
        s = s ^ r;
      end
      msbox[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_sub_word(input logic [31:0] w);
    return {msbox[w[31:24]], msbox[w[23:16]], msbox[w[15:8]], msbox[w[7:0]]};
  endfunction

  function automatic logic [31:0] m_rcon(input int i);
    logic [7:0] r = 8'h01;
    for (int k = 0; k < i; k++) r = xtime(r);
    return {r, 24'h0};
  endfunction

  // Standard FIPS-197 forward expansion of a round-0 key into all eleven round keys.
  task automatic expand_forward(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = m_sub_word({t[23:0], t[31:24]}) ^ m_rcon(i/4 - 1);
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic inverse_chain(input logic [127:0] k10);
    logic [31:0] a, b, c, d;
    exp_keys[10] = k10;
    for (int r = 10; r >= 1; r--) begin
      {a, b, c, d} = exp_keys[r];
      d = d ^ c;
      c = c ^ b;
      b = b ^ a;
      a = a ^ m_sub_word({d[23:0], d[31:24]}) ^ m_rcon(r - 1);
      exp_keys[r-1] = {a, b, c, d};
    end
  endtask

  task automatic run_seq(input logic [127:0] k10, input int ready_pct, input int inj_round,
                         input bit skip_start, input bit chain, input logic [127:0] chain_key);
    int beat   = 0;
    int cycles = 0;
    bit rdy;
    if (!skip_start) begin
      kif.start  = 1'b1;
      kif.key_in = k10;
      @(negedge clk);
      kif.start  = 1'b0;
      kif.key_in = ~k10;
    end
    while (beat < 11 && cycles < 300) begin
      check("key_valid", 128'(kif.key_valid), 128'd1);
      check("key_round", 128'(kif.key_round), 128'(10 - beat));
      check("key_out", kif.key_out, exp_keys[10 - beat]);
      check("busy", 128'(kif.busy), 128'd1);
      if (inj_round >= 0 && int'(kif.key_round) == inj_round) begin
        kif.start  = 1'b1;
        kif.key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        kif.start = 1'b0;
      end
      rdy = (ready_pct >= 100) || ($urandom_range(0, 99) < ready_pct);
      kif.key_ready = rdy;
      if (rdy) beat++;
      cycles++;
      @(negedge clk);
    end
    kif.start = 1'b0;
    check("beats", 128'(beat), 128'd11);
    if (ready_pct >= 100) check("cycles", 128'(cycles), 128'd11);
    check("done", 128'(kif.done), 128'd1);
    check("valid_after", 128'(kif.key_valid), 128'd0);
    check("busy_after", 128'(kif.busy), 128'd0);
    if (chain) begin
      kif.start  = 1'b1;
      kif.key_in = chain_key;
      @(negedge clk);
      kif.start  = 1'b0;
      kif.key_in = ~chain_key;
    end else begin
      @(negedge clk);
      check("done_pulse", 128'(kif.done), 128'd0);
      check("idle_valid", 128'(kif.key_valid), 128'd0);
    end
  endtask

  task automatic mid_run_reset();
    int cycles = 0;
    kif.start     = 1'b1;
    kif.key_in    = FIPS_R10;
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.start = 1'b0;
    while (!(kif.key_valid && kif.key_round == 4'd5) && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("reach_round5", 128'(kif.key_round), 128'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 128'(kif.key_valid), 128'd0);
    check("rst_busy", 128'(kif.busy), 128'd0);
    check("rst_done", 128'(kif.done), 128'd0);
    check("rst_key", kif.key_out, 128'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done", 128'(kif.done), 128'd0);
      check("post_rst_valid", 128'(kif.key_valid), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] k0;
    build_sbox();

    rst_n         = 1'b0;
    kif.start     = 1'b1;
    kif.key_in    = {$urandom, $urandom, $urandom, $urandom};
    kif.key_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_key", kif.key_out, 128'd0);
    check("reset_round", 128'(kif.key_round), 128'd0);
    check("reset_valid", 128'(kif.key_valid), 128'd0);
    check("reset_busy", 128'(kif.busy), 128'd0);
    check("reset_done", 128'(kif.done), 128'd0);
    rst_n     = 1'b1;
    kif.start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_valid0", 128'(kif.key_valid), 128'd0);
    check("idle_busy0", 128'(kif.busy), 128'd0);

    inverse_chain(FIPS_R10);
    exp_keys[9] = FIPS_R9;
    exp_keys[1] = FIPS_R1;
    exp_keys[0] = FIPS_R0;
    run_seq(FIPS_R10, 100, -1, 1'b0, 1'b0, 128'd0);
    run_seq(FIPS_R10, 50, -1, 1'b0, 1'b0, 128'd0);
    run_seq(FIPS_R10, 100, 7, 1'b0, 1'b0, 128'd0);
    run_seq(FIPS_R10, 60, 7, 1'b0, 1'b0, 128'd0);

    mid_run_reset();
    run_seq(FIPS_R10, 100, -1, 1'b0, 1'b0, 128'd0);

    run_seq(FIPS_R10, 100, -1, 1'b0, 1'b1, 128'd0);
    inverse_chain(128'd0);
    run_seq(128'd0, 100, -1, 1'b1, 1'b0, 128'd0);

    for (int n = 0; n < 1000; n++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      expand_forward(k0);
      run_seq(exp_keys[10], (n % 2 == 0) ? 100 : 75, -1, 1'b0, 1'b0, 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 start  input  1  single-cycle request; loads key_in; honoured only in IDLE.
REQ-005 key_in  input  128  AES-128 round-10 key; [127:96]=w0 … [31:0]=w3.
REQ-006 key_out  output  128  current round key, registered; same word order as key_in.
REQ-007 key_round  output  4  round index of key_out, 10 down to 0.
REQ-008 key_valid  output  1  key_out/key_round valid.
REQ-009 key_ready  input  1  consumer accepts the beat when key_valid&key_ready.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle pulse after the round-0 beat is accepted.

Function
REQ-012 The FSM SHALL have the states IDLE and RUN.
REQ-013 In IDLE with start=1: register key_in, key_round=10, key_valid=1, busy=1, go RUN; key_valid is first seen one cycle after start.
REQ-014 In IDLE with start=0: the FSM stays in IDLE, key_valid=0, and key_out holds its value.
REQ-015 In RUN, when key_valid&key_ready and key_round>0: key_out <= inverse step of key_out, key_round <= key_round-1, key_valid stays 1.
REQ-016 Inverse step from round r (w0..w3): w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^rcon(r-1).
REQ-017 RotWord SHALL be a left byte rotate {b1,b2,b3,b0}; SubWord SHALL apply the AES forward S-box per byte.
REQ-018 rcon index r-1 SHALL map 0..9 to 01,02,04,08,10,20,40,80,1b,36 in the MSB byte with the lower 24 bits zero.
REQ-019 In RUN, when key_valid&key_ready and key_round=0: key_valid <= 0, busy <= 0, done <= 1 for one cycle, FSM goes to IDLE.
REQ-020 In RUN with key_ready=0: key_out, key_round and key_valid SHALL hold unchanged (no bubble, no skip).
REQ-021 With key_ready held at 1, rounds 10..0 SHALL appear on 11 consecutive cycles, and done SHALL appear the cycle after round 0.
REQ-022 start while in RUN SHALL be ignored, with no reload and no effect on the sequence.
REQ-023 start in the same cycle as the done pulse SHALL be honoured, because the FSM is already in IDLE.
REQ-024 The inverse step SHALL be combinational from the key_out register; one round per cycle with no extra pipeline stage.

Reset
REQ-025 On a cycle with rst_n=0: FSM=IDLE, key_out=0, key_round=0, key_valid=0, busy=0, done=0.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence, output nothing further, and produce no done pulse.
REQ-027 start coincident with rst_n=0 SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the rcon table/function, NUM_ROUNDS=10, the key width 128, and the FSM state type.
REQ-029 SubWord SHALL use four instances of the team's existing forward S-box module (FORWARD_SUBSTITUTION_BOX); no new sub-module.
REQ-030 No latches and no combinational path from key_ready to key_out SHALL exist; key_ready SHALL drive only register enables.

Verification
REQ-031 FIPS-197 key: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and ready=1 -> round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done the cycle after round 0.
REQ-032 Backpressure: same key, key_ready toggled pseudo-randomly -> identical 11-beat sequence, key_out stable while stalled, never more than 11 beats.
REQ-033 Mid-run reset: reset asserted at round 5 -> next cycle key_valid=0, busy=0, and no done pulse; a fresh start then yields the full sequence.
REQ-034 start while busy: a second start with a different key at round 7 -> sequence unaffected.
REQ-035 Back-to-back: start in the done cycle with key_in=all zeros -> key_valid next cycle, key_round=10, then rounds match a software inverse model.
REQ-036 Random keys: 1000 random round-0 keys expanded forward by the model, round 10 fed in -> all 11 outputs match the model.
